// File: rtl/aes_subbytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : aes_subbytes_seq
//  Description : Sequences SubBytes / InvSubBytes over a 128-bit AES state
//                through LANES shared external byte S-boxes, one lane group
//                per cycle, with valid/ready handshakes on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module aes_subbytes_seq #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [127:0]         in_data,
    input  logic                 in_dec,
    output logic [8*LANES-1:0]   sbox_u,
    output logic                 sbox_dec,
    input  logic [8*LANES-1:0]   sbox_s,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [127:0]         out_data,
    output logic                 out_dec
);

    localparam int c_GROUPS = 16 / LANES;
    localparam int c_GW     = (c_GROUPS > 1) ? $clog2(c_GROUPS) : 1;
    localparam int c_LW     = 8 * LANES;

    localparam logic [c_GW-1:0] c_LAST = c_GW'(c_GROUPS - 1);
    localparam logic [c_GW-1:0] c_ONE  = c_GW'(1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [127:0]    r_src;
    logic [127:0]    r_res;
    logic [c_GW-1:0] r_grp;
    logic            r_dec;

    // State register; reset abandons any state in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode: accept in IDLE, walk groups in RUN, hand off in DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (in_valid)         w_state_nxt = c_S_RUN;
            c_S_RUN:  if (r_grp == c_LAST)  w_state_nxt = c_S_DONE;
            c_S_DONE: if (out_ready)        w_state_nxt = c_S_IDLE;
            default:                        w_state_nxt = c_S_IDLE;
        endcase
    end

    // Datapath: capture the source on accept, collect S-box results per group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src <= '0;
            r_res <= '0;
            r_grp <= '0;
            r_dec <= 1'b0;
        end else begin
            if (r_state == c_S_IDLE && in_valid) begin
                r_src <= in_data;
                r_dec <= in_dec;
                r_grp <= '0;
            end
            if (r_state == c_S_RUN) begin
                // Lane 0 owns the lowest-numbered byte, i.e. the top bits.
                for (int g = 0; g < c_GROUPS; g++) begin
                    if (r_grp == c_GW'(g)) begin
                        r_res[127-c_LW*g -: c_LW] <= sbox_s;
                    end
                end
                // Counter stops at the last group so it never wraps in RUN.
                if (r_grp != c_LAST) begin
                    r_grp <= r_grp + c_ONE;
                end
            end
        end
    end

    // S-box lane drive: the current group's bytes in RUN, quiet otherwise.
    always_comb begin
        sbox_u = '0;
        if (r_state == c_S_RUN) begin
            for (int g = 0; g < c_GROUPS; g++) begin
                if (r_grp == c_GW'(g)) begin
                    sbox_u = r_src[127-c_LW*g -: c_LW];
                end
            end
        end
    end

    // Handshake and result outputs decode only from state and registers.
    always_comb begin
        in_ready  = (r_state == c_S_IDLE) && !rst;
        out_valid = (r_state == c_S_DONE);
        out_data  = r_res;
        out_dec   = r_dec;
        sbox_dec  = r_dec;
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_subbytes_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_subbytes_seq
//  Description : Self-checking bench for aes_subbytes_seq at LANES = 4, 1, 16,
//                with a GF(2^8)-arithmetic S-box model on the lanes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_subbytes_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [2:0]   in_valid_v, in_dec_v, out_ready_v;
    logic [2:0]   in_ready_v, out_valid_v, out_dec_v, sbox_dec_v;
    logic [127:0] in_data_a  [3];
    logic [127:0] out_data_a [3];
    logic [127:0] su_a       [3];

    int checks   = 0;
    int failures = 0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic       hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] r, e;
        r = 8'h01; e = 8'd254;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (e[i]) r = gmul(r, x);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [7:0] r;
        r = (b << n) | (b >> (8 - n));
        return r;
    endfunction

    function automatic logic [7:0] sb(input logic [7:0] x, input logic dec);
        logic [7:0] b;
        if (!dec) begin
            b = ginv(x);
            return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        b = rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05;
        return ginv(b);
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d, input logic dec);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sb(d[127-8*i -: 8], dec);
        return r;
    endfunction

    function automatic int groups(input int k);
        return (k == 0) ? 4 : (k == 1) ? 16 : 1;
    endfunction

    // Bytes g*L .. g*L+L-1 of src, right-aligned.
    function automatic logic [127:0] grp_bytes(input logic [127:0] src, input int l, input int g);
        logic [127:0] t;
        t = src << (8 * l * g);
        return t >> (128 - 8 * l);
    endfunction

    // ---------------- DUTs with S-box lane models ----------------
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int L = (k == 0) ? 4 : (k == 1) ? 1 : 16;
        logic [8*L-1:0] su, ss;
        logic           sd, ir, ov, od;
        logic [127:0]   odata;

        aes_subbytes_seq #(.LANES(L)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[k]),
            .in_ready  (ir),
            .in_data   (in_data_a[k]),
            .in_dec    (in_dec_v[k]),
            .sbox_u    (su),
            .sbox_dec  (sd),
            .sbox_s    (ss),
            .out_valid (ov),
            .out_ready (out_ready_v[k]),
            .out_data  (odata),
            .out_dec   (od)
        );

        always_comb begin
            ss = '0;
            for (int i = 0; i < L; i++) ss[8*L-1-8*i -: 8] = sb(su[8*L-1-8*i -: 8], sd);
        end

        assign in_ready_v[k]  = ir;
        assign out_valid_v[k] = ov;
        assign out_dec_v[k]   = od;
        assign sbox_dec_v[k]  = sd;
        assign out_data_a[k]  = odata;
        assign su_a[k]        = 128'(su);
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present a state and return just after the accepting edge.
    task automatic send(input int k, input logic [127:0] d, input logic dec);
        int n;
        @(negedge clk);
        in_valid_v[k] = 1'b1; in_data_a[k] = d; in_dec_v[k] = dec;
        n = 0;
        while (!in_ready_v[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("accept_timeout", 128'(n), 128'(0));
        @(posedge clk);
        #1;
        in_valid_v[k] = 1'b0;
        in_data_a[k]  = {$urandom, $urandom, $urandom, $urandom};
        in_dec_v[k]   = ~dec;
    endtask

    // Follow a state from its accept edge to DONE, checking lanes and result.
    task automatic collect(input int k, input logic [127:0] src, input logic dec, input logic [127:0] exp);
        int n, g, l;
        g = groups(k); l = 16 / g; n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (out_valid_v[k] || n > 60) break;
            if (n <= g) begin
                check("lane_u", su_a[k], grp_bytes(src, l, n - 1));
                check("busy_ready", 128'(in_ready_v[k]), 128'(0));
                check("lane_dec", 128'(sbox_dec_v[k]), 128'(dec));
            end
        end
        check("latency", 128'(n), 128'(g + 1));
        check("data", out_data_a[k], exp);
        check("out_dec", 128'(out_dec_v[k]), 128'(dec));
        check("done_u_quiet", su_a[k], 128'(0));
    endtask

    task automatic release_out(input int k);
        out_ready_v[k] = 1'b1;
        @(negedge clk);
        out_ready_v[k] = 1'b0;
        check("idle_valid", 128'(out_valid_v[k]), 128'(0));
        check("idle_ready", 128'(in_ready_v[k]), 128'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d, d2, r;
        logic         dec;
        int           pulses;

        rst = 1'b0;
        in_valid_v = '0; in_dec_v = '0; out_ready_v = '0;
        for (int k = 0; k < 3; k++) in_data_a[k] = '0;
        #1 rst = 1'b1;
        #1;
        check("rst_in_ready", 128'(in_ready_v[0]), 128'(0));
        check("rst_out_valid", 128'(out_valid_v[0]), 128'(0));
        check("rst_out_data", out_data_a[0], 128'(0));
        check("rst_out_dec", 128'(out_dec_v[0]), 128'(0));
        check("rst_sbox_u", su_a[0], 128'(0));
        check("rst_sbox_dec", 128'(sbox_dec_v[0]), 128'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1 check("post_rst_ready", 128'(in_ready_v[0]), 128'(1));

        // Known vectors, LANES=4
        send(0, 128'h00112233445566778899aabbccddeeff, 1'b0);
        collect(0, 128'h00112233445566778899aabbccddeeff, 1'b0, 128'h638293c31bfc33f5c4eeacea4bc12816);
        release_out(0);
        send(0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1);
        collect(0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1, 128'h00112233445566778899aabbccddeeff);
        release_out(0);
        send(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0);
        collect(0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 128'h637c777bf26b6fc53001672bfed7ab76);
        release_out(0);

        // Back-pressure with a queued input
        d = {$urandom, $urandom, $urandom, $urandom};
        send(0, d, 1'b0);
        collect(0, d, 1'b0, model(d, 1'b0));
        d2 = {$urandom, $urandom, $urandom, $urandom};
        in_valid_v[0] = 1'b1; in_data_a[0] = d2; in_dec_v[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data", out_data_a[0], model(d, 1'b0));
            check("bp_ready", 128'(in_ready_v[0]), 128'(0));
            check("bp_valid", 128'(out_valid_v[0]), 128'(1));
        end
        release_out(0);
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0; in_data_a[0] = '0; in_dec_v[0] = 1'b0;
        collect(0, d2, 1'b1, model(d2, 1'b1));
        release_out(0);

        // Asynchronous reset during RUN grp=2
        send(0, {16{8'h53}}, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ready", 128'(in_ready_v[0]), 128'(0));
        check("mid_rst_valid", 128'(out_valid_v[0]), 128'(0));
        check("mid_rst_data", out_data_a[0], 128'(0));
        check("mid_rst_dec", 128'(out_dec_v[0]), 128'(0));
        check("mid_rst_u", su_a[0], 128'(0));
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid_v[0]) pulses++;
        end
        check("no_partial", 128'(pulses), 128'(0));
        send(0, {16{8'h53}}, 1'b0);
        collect(0, {16{8'h53}}, 1'b0, {16{8'hed}});
        release_out(0);

        // Random sweep on every lane count
        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 5; t++) begin
                d   = {$urandom, $urandom, $urandom, $urandom};
                dec = 1'($urandom_range(0, 1));
                send(k, d, dec);
                collect(k, d, dec, model(d, dec));
                release_out(k);
            end
        end

        // Random round trip, LANES=1
        d = {$urandom, $urandom, $urandom, $urandom};
        r = model(d, 1'b0);
        send(1, d, 1'b0);
        collect(1, d, 1'b0, r);
        release_out(1);
        send(1, r, 1'b1);
        collect(1, r, 1'b1, d);
        release_out(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
